// File: rtl/vga_mem_reader.sv
// vga_mem_reader
//   Read-side master for the data memory's VGA port. Generates VGA timing
//   (640x480@60 with default parameters) from clk, maps the visible area onto
//   a GRID_COLS x GRID_ROWS grid of cells (one 32-bit word per cell), drives
//   addr_vga, and registers RGB888 plus syncs from the combinational data_vga.
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous active-high reset
//   addr_vga     out  32  byte address to data memory read port
//   data_vga     in   32  word returned combinationally for addr_vga
//   vga_hsync    out  1   horizontal sync, active low
//   vga_vsync    out  1   vertical sync, active low
//   vga_r/g/b    out  8   colour channels
//   vga_blank_n  out  1   1 = pixel in visible area
//   pixel_tick   out  1   1-clk strobe per pixel period
//   frame_start  out  1   1-clk pulse when pixel (0,0) is on the outputs
module vga_mem_reader #(
   parameter int          CLK_DIV    = 2,
   parameter int          H_ACTIVE   = 640,
   parameter int          H_FP       = 16,
   parameter int          H_SYNC     = 96,
   parameter int          H_BP       = 48,
   parameter int          V_ACTIVE   = 480,
   parameter int          V_FP       = 10,
   parameter int          V_SYNC     = 2,
   parameter int          V_BP       = 33,
   parameter int          GRID_COLS  = 8,
   parameter int          GRID_ROWS  = 8,
   parameter int          CELL_W     = 80,
   parameter int          CELL_H     = 60,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter bit          GRID_LINES = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] addr_vga,
   input  logic [31:0] data_vga,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_blank_n,
   output logic        pixel_tick,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // One spare bit of headroom so the sync-end compare value always fits.
   localparam int HW  = $clog2(H_TOTAL + 1);
   localparam int VW  = $clog2(V_TOTAL + 1);
   localparam int DW  = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
   localparam int SXW = (CELL_W    > 1) ? $clog2(CELL_W)    : 1;
   localparam int SYW = (CELL_H    > 1) ? $clog2(CELL_H)    : 1;
   localparam int CXW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
   localparam int CYW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;

   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0]  HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0]  VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SXW-1:0] SX_LAST  = SXW'(CELL_W - 1);
   localparam logic [SYW-1:0] SY_LAST  = SYW'(CELL_H - 1);
   localparam logic [CXW-1:0] CX_LAST  = CXW'(GRID_COLS - 1);
   localparam logic [CYW-1:0] CY_LAST  = CYW'(GRID_ROWS - 1);

   logic [DW-1:0]  div_cnt_q,    div_cnt_d;
   logic           pixel_tick_q, pixel_tick_d;
   logic [HW-1:0]  h_cnt_q,      h_cnt_d;
   logic [VW-1:0]  v_cnt_q,      v_cnt_d;
   logic [SXW-1:0] sub_x_q,      sub_x_d;
   logic [SYW-1:0] sub_y_q,      sub_y_d;
   logic [CXW-1:0] cell_x_q,     cell_x_d;
   logic [CYW-1:0] cell_y_q,     cell_y_d;
   logic           hsync_q,      hsync_d;
   logic           vsync_q,      vsync_d;
   logic           blank_n_q,    blank_n_d;
   logic [7:0]     r_q,          r_d;
   logic [7:0]     g_q,          g_d;
   logic [7:0]     b_q,          b_d;
   logic           frame_start_q, frame_start_d;

   logic           active;
   logic [31:0]    cell_idx;
   logic           unused_data;

   // Top byte of each cell word carries no colour.
   assign unused_data = ^data_vga[31:24];

   // Stage 0: address straight from the counters.
   always_comb begin
      active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      cell_idx = 32'(cell_y_q) * 32'(GRID_COLS) + 32'(cell_x_q);
      addr_vga = active ? (BASE_ADDR + (cell_idx << 2)) : BASE_ADDR;
   end

   always_comb begin
      div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
      // Registered strobe: high during the cycle in which div_cnt_q is last.
      pixel_tick_d  = (div_cnt_d == DIV_LAST);
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      sub_x_d       = sub_x_q;
      sub_y_d       = sub_y_q;
      cell_x_d      = cell_x_q;
      cell_y_d      = cell_y_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      blank_n_d     = blank_n_q;
      r_d           = r_q;
      g_d           = g_q;
      b_d           = b_q;
      frame_start_d = 1'b0;

      if (pixel_tick_q) begin
         // Stage 1: everything sampled from the same counter values, so
         // syncs and colour leave together one tick after the address.
         blank_n_d     = active;
         hsync_d       = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
         vsync_d       = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
         frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
         if (!active) begin
            {r_d, g_d, b_d} = 24'h000000;
         end else if (GRID_LINES && ((sub_x_q == '0) || (sub_y_q == '0))) begin
            {r_d, g_d, b_d} = 24'h404040;
         end else begin
            {r_d, g_d, b_d} = data_vga[23:0];
         end

         // Cell counters saturate at the last column/row; past the visible
         // area their value is never used, so they simply park there.
         if (h_cnt_q == H_LAST) begin
            h_cnt_d  = '0;
            sub_x_d  = '0;
            cell_x_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d  = '0;
               sub_y_d  = '0;
               cell_y_d = '0;
            end else begin
               v_cnt_d = v_cnt_q + VW'(1);
               if (sub_y_q == SY_LAST) begin
                  sub_y_d = '0;
                  if (cell_y_q != CY_LAST) cell_y_d = cell_y_q + CYW'(1);
               end else begin
                  sub_y_d = sub_y_q + SYW'(1);
               end
            end
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
            if (sub_x_q == SX_LAST) begin
               sub_x_d = '0;
               if (cell_x_q != CX_LAST) cell_x_d = cell_x_q + CXW'(1);
            end else begin
               sub_x_d = sub_x_q + SXW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q     <= '0;
         pixel_tick_q  <= 1'b0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         sub_x_q       <= '0;
         sub_y_q       <= '0;
         cell_x_q      <= '0;
         cell_y_q      <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         blank_n_q     <= 1'b0;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         pixel_tick_q  <= pixel_tick_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         sub_x_q       <= sub_x_d;
         sub_y_q       <= sub_y_d;
         cell_x_q      <= cell_x_d;
         cell_y_q      <= cell_y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_n_q     <= blank_n_d;
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;
   assign vga_blank_n = blank_n_q;
   assign pixel_tick  = pixel_tick_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_mem_reader.sv
// Bench for vga_mem_reader using a shrunken timing set so whole frames run
// quickly. Expected outputs come from an arithmetic model of the raster:
// clk cycles since reset release -> pixel index -> (h, v) -> outputs.
module tb_vga_mem_reader;

   localparam int CLK_DIV = 2;
   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 12, VF = 1, VS = 2, VB = 2;
   localparam int COLS = 4, ROWS = 3, CW = 4, CH = 4;
   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr_vga;
   logic [31:0] data_vga;
   logic        vga_hsync, vga_vsync, vga_blank_n, pixel_tick, frame_start;
   logic [7:0]  vga_r, vga_g, vga_b;

   logic [31:0] mem [0:63];
   logic [31:0] widx;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic        hs;
      logic        vs;
      logic        bn;
      logic        pt;
      logic        fs;
      logic [23:0] rgb;
   } obs_t;

   vga_mem_reader #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .GRID_COLS(COLS), .GRID_ROWS(ROWS), .CELL_W(CW), .CELL_H(CH),
      .BASE_ADDR(BASE), .GRID_LINES(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .addr_vga(addr_vga), .data_vga(data_vga),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_blank_n(vga_blank_n), .pixel_tick(pixel_tick), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   always_comb begin
      widx     = (addr_vga - BASE) >> 2;
      data_vga = (widx < 32'd64) ? mem[widx[5:0]] : 32'hDEAD_BEEF;
   end

   function automatic obs_t observe();
      obs_t o;
      o.addr = addr_vga;
      o.hs   = vga_hsync;
      o.vs   = vga_vsync;
      o.bn   = vga_blank_n;
      o.pt   = pixel_tick;
      o.fs   = frame_start;
      o.rgb  = {vga_r, vga_g, vga_b};
      return o;
   endfunction

   // n = clk cycles since the last edge that sampled rst high.
   function automatic obs_t model(input int n);
      obs_t o;
      int k, hn, vn, p, h, v;
      logic [31:0] w;
      k  = n / CLK_DIV;             // ticks already taken
      hn = k % HT;
      vn = (k / HT) % VT;
      o.pt   = ((n % CLK_DIV) == CLK_DIV - 1);
      o.addr = (hn < HA && vn < VA) ? BASE + 32'(((vn / CH) * COLS + hn / CW) * 4) : BASE;
      o.hs  = 1'b1;
      o.vs  = 1'b1;
      o.bn  = 1'b0;
      o.fs  = 1'b0;
      o.rgb = 24'h0;
      if (k > 0) begin
         p = k - 1;                 // pixel now on the pins
         h = p % HT;
         v = (p / HT) % VT;
         o.hs = !(h >= HA + HF && h < HA + HF + HS);
         o.vs = !(v >= VA + VF && v < VA + VF + VS);
         o.bn = (h < HA && v < VA);
         o.fs = ((n % CLK_DIV) == 0) && h == 0 && v == 0;
         if (o.bn) begin
            if ((h % CW) == 0 || (v % CH) == 0) begin
               o.rgb = 24'h404040;
            end else begin
               w     = mem[(v / CH) * COLS + h / CW];
               o.rgb = w[23:0];
            end
         end
      end
      return o;
   endfunction

   task automatic fill_mem();
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      obs_t e, a;
      fill_mem();
      e = model(0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         a = observe();
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL reset_hold i=%0d actual=%h expected=%h", i, a, e);
         end
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat ($urandom_range(40, 200)) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         a = observe();
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL reset_running i=%0d actual=%h expected=%h", i, a, e);
         end
      end
   endtask

   task automatic test_line();
      obs_t e, a;
      int cnt_pt, lows, first_low;
      cnt_pt = 0; lows = 0; first_low = -1;
      fill_mem();
      do_reset(2);
      for (int n = 0; n < CLK_DIV * HT + 2; n++) begin
         @(negedge clk);
         e = model(n);
         a = observe();
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL line n=%0d actual=%h expected=%h", n, a, e);
         end
         if (n < CLK_DIV * HT && a.pt === 1'b1) cnt_pt++;
         if (n >= CLK_DIV && n <= CLK_DIV * HT && (n % CLK_DIV) == 0 && a.hs === 1'b0) begin
            lows++;
            if (first_low < 0) first_low = n / CLK_DIV - 1;
         end
      end
      n_cmp++;
      if (cnt_pt != HT) begin
         n_bad++;
         $display("FAIL line_ticks actual=%0d expected=%0d", cnt_pt, HT);
      end
      n_cmp++;
      if (lows != HS) begin
         n_bad++;
         $display("FAIL hsync_width actual=%0d expected=%0d", lows, HS);
      end
      n_cmp++;
      if (first_low != HA + HF) begin
         n_bad++;
         $display("FAIL hsync_start actual=%0d expected=%0d", first_low, HA + HF);
      end
   endtask

   task automatic test_frame();
      obs_t e, a;
      int cnt_pt, cnt_fs, hlows, vlows, first_v;
      cnt_pt = 0; cnt_fs = 0; hlows = 0; vlows = 0; first_v = -1;
      fill_mem();
      do_reset(1);
      for (int n = 0; n < CLK_DIV * FR + 4; n++) begin
         @(negedge clk);
         e = model(n);
         a = observe();
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL frame n=%0d actual=%h expected=%h", n, a, e);
         end
         if (n < CLK_DIV * FR && a.pt === 1'b1) cnt_pt++;
         if (a.fs === 1'b1) cnt_fs++;
         if (n >= CLK_DIV && n <= CLK_DIV * FR && (n % CLK_DIV) == 0) begin
            if (a.hs === 1'b0) hlows++;
            if (a.vs === 1'b0) begin
               vlows++;
               if (first_v < 0) first_v = n / CLK_DIV - 1;
            end
         end
      end
      n_cmp++;
      if (cnt_pt != FR) begin
         n_bad++;
         $display("FAIL frame_ticks actual=%0d expected=%0d", cnt_pt, FR);
      end
      n_cmp++;
      if (cnt_fs != 2) begin
         n_bad++;
         $display("FAIL frame_start_count actual=%0d expected=2", cnt_fs);
      end
      n_cmp++;
      if (hlows != HS * VT) begin
         n_bad++;
         $display("FAIL frame_hsync_low actual=%0d expected=%0d", hlows, HS * VT);
      end
      n_cmp++;
      if (vlows != VS * HT) begin
         n_bad++;
         $display("FAIL vsync_width actual=%0d expected=%0d", vlows, VS * HT);
      end
      n_cmp++;
      if (first_v != (VA + VF) * HT) begin
         n_bad++;
         $display("FAIL vsync_start actual=%0d expected=%0d", first_v, (VA + VF) * HT);
      end
   endtask

   task automatic test_addr_map();
      int th [7];
      int tv [7];
      logic [31:0] ta [7];
      obs_t e, a;
      int hits;
      th = '{0, CW - 1, CW, 0, HA - 1, HA, 0};
      tv = '{0, 0, 0, CH, VA - 1, 0, VA};
      ta = '{32'h100, 32'h100, 32'h104, 32'h110, 32'h12C, 32'h100, 32'h100};
      hits = 0;
      fill_mem();
      do_reset(1);
      for (int n = 0; n < CLK_DIV * FR; n++) begin
         @(negedge clk);
         e = model(n);
         a = observe();
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL addr_run n=%0d actual=%h expected=%h", n, a, e);
         end
         for (int i = 0; i < 7; i++) begin
            if (n == CLK_DIV * (tv[i] * HT + th[i])) begin
               hits++;
               n_cmp++;
               if (addr_vga !== ta[i]) begin
                  n_bad++;
                  $display("FAIL addr_point h=%0d v=%0d actual=%h expected=%h",
                           th[i], tv[i], addr_vga, ta[i]);
               end
            end
         end
      end
      n_cmp++;
      if (hits != 7) begin
         n_bad++;
         $display("FAIL addr_points_reached actual=%0d expected=7", hits);
      end
   endtask

   task automatic test_colour();
      int px [4];
      int py [4];
      logic [24:0] pe [4];     // {blank_n, rgb}
      obs_t e, a;
      int hits, p0;
      px = '{5, 4, 5, HA + 1};
      py = '{5, 5, 4, 5};
      pe = '{{1'b1, 24'hFF8000}, {1'b1, 24'h404040}, {1'b1, 24'h404040}, {1'b0, 24'h000000}};
      hits = 0;
      fill_mem();
      mem[5] = 32'hAAFF_8000;
      do_reset(1);
      p0 = 5 * HT + 5;
      for (int n = 0; n < CLK_DIV * (VA * HT); n++) begin
         @(negedge clk);
         e = model(n);
         a = observe();
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL colour_run n=%0d actual=%h expected=%h", n, a, e);
         end
         for (int i = 0; i < 4; i++) begin
            if (n == CLK_DIV * (py[i] * HT + px[i] + 1)) begin
               hits++;
               n_cmp++;
               if ({vga_blank_n, vga_r, vga_g, vga_b} !== pe[i]) begin
                  n_bad++;
                  $display("FAIL colour_pixel x=%0d y=%0d actual=%h expected=%h",
                           px[i], py[i], {vga_blank_n, vga_r, vga_g, vga_b}, pe[i]);
               end
            end
         end
         // Counters already at (5,5); pins still show the grid line at (4,5).
         if (n == CLK_DIV * p0) begin
            hits++;
            n_cmp++;
            if ({vga_r, vga_g, vga_b} !== 24'h404040) begin
               n_bad++;
               $display("FAIL colour_latency actual=%h expected=404040", {vga_r, vga_g, vga_b});
            end
         end
      end
      n_cmp++;
      if (hits != 5) begin
         n_bad++;
         $display("FAIL colour_points_reached actual=%0d expected=5", hits);
      end
   endtask

   task automatic test_midframe_reset();
      obs_t e, a;
      int vr, hr, nstop, cnt_fs, first_fs, hlows, vlows;
      for (int it = 0; it < 3; it++) begin
         fill_mem();
         do_reset(1);
         vr    = $urandom_range(1, VT - 2);
         hr    = $urandom_range(0, HT - 1);
         nstop = CLK_DIV * (vr * HT + hr) + $urandom_range(0, CLK_DIV - 1);
         for (int n = 0; n <= nstop; n++) begin
            @(negedge clk);
            e = model(n);
            a = observe();
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL midrst_pre it=%0d n=%0d actual=%h expected=%h", it, n, a, e);
            end
         end
         do_reset(1);
         cnt_fs = 0; first_fs = -1; hlows = 0; vlows = 0;
         for (int n = 0; n < CLK_DIV * FR + 4; n++) begin
            @(negedge clk);
            e = model(n);
            a = observe();
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL midrst_post it=%0d n=%0d actual=%h expected=%h", it, n, a, e);
            end
            if (a.fs === 1'b1) begin
               cnt_fs++;
               if (first_fs < 0) first_fs = n;
            end
            if (n >= CLK_DIV && n <= CLK_DIV * FR && (n % CLK_DIV) == 0) begin
               if (a.hs === 1'b0) hlows++;
               if (a.vs === 1'b0) vlows++;
            end
         end
         n_cmp++;
         if (first_fs != CLK_DIV) begin
            n_bad++;
            $display("FAIL midrst_first_fs it=%0d actual=%0d expected=%0d", it, first_fs, CLK_DIV);
         end
         n_cmp++;
         if (cnt_fs != 2) begin
            n_bad++;
            $display("FAIL midrst_fs_count it=%0d actual=%0d expected=2", it, cnt_fs);
         end
         n_cmp++;
         if (hlows != HS * VT || vlows != VS * HT) begin
            n_bad++;
            $display("FAIL midrst_sync_counts it=%0d actual=%0d/%0d expected=%0d/%0d",
                     it, hlows, vlows, HS * VT, VS * HT);
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_addr_map();
      test_colour();
      test_midframe_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
